ethernet_mmio_arbiter: RTL and testbench

- Round-robin arbiter that shares the Ethernet controller's single MMIO port (14-bit addr, write/read enables, op size, write data, synchronous 1-cycle read data) among num_req_p requesters, e.g. core I/O path and a debug/DMA engine.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- One transaction is outstanding at a time.
- Sits between the requesters and the controller's addr/write_en/read_en/op_size/write_data/read_data pins.

---
 rtl/ethernet_mmio_arbiter_pkg.sv | 22 ++
 rtl/ethernet_mmio_arbiter_rr_picker.sv | 32 +++
 rtl/ethernet_mmio_arbiter.sv | 150 +++++++++++++++
 tb/tb_ethernet_mmio_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_mmio_arbiter_pkg.sv
// Shared types for the Ethernet MMIO arbiter: FSM states and the latched command layout.
package ethernet_mmio_arbiter_pkg;

  localparam int addr_width_c = 14;
  localparam int data_width_c = 32;
  localparam int size_width_c = 2;

  typedef enum logic [1:0] {
    e_idle,
    e_issue,
    e_rdata,
    e_resp
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [addr_width_c-1:0] addr;
    logic [size_width_c-1:0] size;
    logic [data_width_c-1:0] data;
  } cmd_t;

endpackage

// File: rtl/ethernet_mmio_arbiter_rr_picker.sv
// Rotate-priority picker: one-hot grant for the first valid requester at or after ptr, wrapping.
module ethernet_rr_picker #(
  parameter int num_req_p = 2,
  parameter int id_w      = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_v,
  input  logic [id_w-1:0]      ptr,
  output logic [num_req_p-1:0] grant,
  output logic [id_w-1:0]      id,
  output logic                 any
);

  always_comb begin
    int              idx;
    logic [id_w-1:0] idx_w;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx   = (int'(ptr) + i) % num_req_p;
      idx_w = id_w'(idx);
      if (!any && req_v[idx_w]) begin
        any          = 1'b1;
        grant[idx_w] = 1'b1;
        id           = idx_w;
      end
    end
  end

endmodule

// File: rtl/ethernet_mmio_arbiter.sv
// Round-robin arbiter sharing the Ethernet controller's single MMIO port, one transaction in flight.
//   state   | meaning
//   e_idle  | waiting; grant and latch a request the cycle it is seen
//   e_issue | command on the MMIO pins for exactly one cycle
//   e_rdata | controller read data valid; capture it
//   e_resp  | response held to the owner until it accepts
module ethernet_mmio_arbiter
  import ethernet_mmio_arbiter_pkg::*;
#(
  parameter int num_req_p    = 2,
  parameter int data_width_p = data_width_c,
  parameter int addr_width_p = addr_width_c,
  parameter int size_width_p = size_width_c
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p-1:0]              req_we_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*size_width_p-1:0] req_size_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              resp_v_o,
  input  logic [num_req_p-1:0]              resp_ready_i,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic [addr_width_p-1:0]           mmio_addr_o,
  output logic                              mmio_write_en_o,
  output logic                              mmio_read_en_o,
  output logic [size_width_p-1:0]           mmio_size_o,
  output logic [data_width_p-1:0]           mmio_wdata_o,
  input  logic [data_width_p-1:0]           mmio_rdata_i,
  output logic                              busy_o
);

  localparam int id_w = $clog2(num_req_p);

  if (addr_width_p != addr_width_c || data_width_p != data_width_c ||
      size_width_p != size_width_c) begin : g_bad_width
    $error("ethernet_mmio_arbiter: widths must match the package command layout");
  end
  if (num_req_p < 2 || num_req_p > 8) begin : g_bad_num_req
    $error("ethernet_mmio_arbiter: num_req_p must be 2..8");
  end

  state_e               state;
  cmd_t                 cmd;
  cmd_t                 next_cmd;
  logic                 write_en;
  logic                 read_en;
  logic                 busy;
  logic [num_req_p-1:0] resp_v;
  logic [data_width_p-1:0] resp_data;
  logic [id_w-1:0]      ptr;
  logic [id_w-1:0]      owner;
  logic [num_req_p-1:0] owner_onehot;
  logic [num_req_p-1:0] pick_grant;
  logic [id_w-1:0]      pick_id;
  logic                 pick_any;

  ethernet_rr_picker #(
    .num_req_p (num_req_p),
    .id_w      (id_w)
  ) u_picker (
    .req_v (req_v_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  always_comb begin
    next_cmd = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (pick_id == id_w'(i)) begin
        next_cmd.we   = req_we_i[i];
        next_cmd.addr = req_addr_i[i*addr_width_p +: addr_width_p];
        next_cmd.size = req_size_i[i*size_width_p +: size_width_p];
        next_cmd.data = req_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  assign owner_onehot = {{(num_req_p-1){1'b0}}, 1'b1} << owner;

  // Gated by reset so a requester holding valid through reset never sees a ready.
  assign req_ready_o = (state == e_idle && reset_n_i) ? pick_grant : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= e_idle;
      cmd       <= '0;
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      busy      <= 1'b0;
      resp_v    <= '0;
      resp_data <= '0;
      ptr       <= '0;
      owner     <= '0;
    end else begin
      unique case (state)
        e_idle: begin
          if (pick_any) begin
            state    <= e_issue;
            owner    <= pick_id;
            cmd      <= next_cmd;
            write_en <= next_cmd.we;
            read_en  <= ~next_cmd.we;
            busy     <= 1'b1;
          end
        end
        e_issue: begin
          cmd      <= '0;
          write_en <= 1'b0;
          read_en  <= 1'b0;
          if (cmd.we) begin
            resp_data <= '0;
            resp_v    <= owner_onehot;
            state     <= e_resp;
          end else begin
            state <= e_rdata;
          end
        end
        e_rdata: begin
          resp_data <= mmio_rdata_i;
          resp_v    <= owner_onehot;
          state     <= e_resp;
        end
        e_resp: begin
          if (resp_ready_i[owner]) begin
            resp_v <= '0;
            busy   <= 1'b0;
            ptr    <= (owner == id_w'(num_req_p - 1)) ? '0 : owner + 1'b1;
            state  <= e_idle;
          end
        end
        default: state <= e_idle;
      endcase
    end
  end

  assign mmio_addr_o     = cmd.addr;
  assign mmio_size_o     = cmd.size;
  assign mmio_wdata_o    = cmd.data;
  assign mmio_write_en_o = write_en;
  assign mmio_read_en_o  = read_en;
  assign resp_v_o        = resp_v;
  assign resp_data_o     = resp_data;
  assign busy_o          = busy;

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Directed bench for ethernet_mmio_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_ethernet_mmio_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // two-requester instance
  logic [1:0]  a_req_v, a_req_ready, a_req_we, a_resp_v, a_resp_ready;
  logic [27:0] a_req_addr;
  logic [3:0]  a_req_size;
  logic [63:0] a_req_data;
  logic [31:0] a_resp_data, a_mmio_wdata, a_mmio_rdata;
  logic [13:0] a_mmio_addr;
  logic [1:0]  a_mmio_size;
  logic        a_wen, a_ren, a_busy;

  // four-requester instance
  logic [3:0]   b_req_v, b_req_ready, b_req_we, b_resp_v, b_resp_ready;
  logic [55:0]  b_req_addr;
  logic [7:0]   b_req_size;
  logic [127:0] b_req_data;
  logic [31:0]  b_resp_data, b_mmio_wdata, b_mmio_rdata;
  logic [13:0]  b_mmio_addr;
  logic [1:0]   b_mmio_size;
  logic         b_wen, b_ren, b_busy;

  ethernet_mmio_arbiter #(.num_req_p(2)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(a_req_v), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_size_i(a_req_size), .req_data_i(a_req_data),
    .resp_v_o(a_resp_v), .resp_ready_i(a_resp_ready), .resp_data_o(a_resp_data),
    .mmio_addr_o(a_mmio_addr), .mmio_write_en_o(a_wen), .mmio_read_en_o(a_ren),
    .mmio_size_o(a_mmio_size), .mmio_wdata_o(a_mmio_wdata), .mmio_rdata_i(a_mmio_rdata),
    .busy_o(a_busy)
  );

  ethernet_mmio_arbiter #(.num_req_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(b_req_v), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_size_i(b_req_size), .req_data_i(b_req_data),
    .resp_v_o(b_resp_v), .resp_ready_i(b_resp_ready), .resp_data_o(b_resp_data),
    .mmio_addr_o(b_mmio_addr), .mmio_write_en_o(b_wen), .mmio_read_en_o(b_ren),
    .mmio_size_o(b_mmio_size), .mmio_wdata_o(b_mmio_wdata), .mmio_rdata_i(b_mmio_rdata),
    .busy_o(b_busy)
  );

  // Controller model: read data appears the cycle after read_en, garbage otherwise.
  always @(posedge clk)
    a_mmio_rdata <= a_ren ? ((a_mmio_addr == 14'h0010) ? 32'hDEADBEEF
                                                        : (32'hA500_0000 | 32'(a_mmio_addr)))
                          : 32'hBAD0_BAD0;
  assign b_mmio_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int both_err = 0;

  always @(negedge clk) if ((a_wen && a_ren) || (b_wen && b_ren)) both_err++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          r;
    logic        we;
    logic [13:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic txn(input vec_t v);
    int   n;
    int   lat;
    logic bad;
    @(negedge clk);
    a_req_we[v.r]            = v.we;
    a_req_addr[v.r*14 +: 14] = v.addr;
    a_req_size[v.r*2 +: 2]   = v.size;
    a_req_data[v.r*32 +: 32] = v.wdata;
    a_req_v[v.r]             = 1'b1;
    #1;
    n = 0;
    while (a_req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", 64'(a_req_ready), 64'(2'b01 << v.r));
    @(negedge clk);
    a_req_v[v.r] = 1'b0;
    #1;
    check("issue_en", 64'({a_wen, a_ren}), 64'({v.we, ~v.we}));
    check("issue_cmd", 64'({a_mmio_addr, a_mmio_size, a_mmio_wdata}), 64'({v.addr, v.size, v.wdata}));
    lat = 1;
    bad = 1'b0;
    while (a_resp_v == 2'b00 && lat < 20) begin
      @(negedge clk); #1; lat++;
      if (a_wen || a_ren || a_mmio_addr != 14'h0 || a_mmio_wdata != 32'h0) bad = 1'b1;
    end
    check("quiet_after_issue", 64'(bad), 64'(0));
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("resp", 64'({a_resp_v, a_resp_data}), 64'({2'b01 << v.r, v.exp_data}));
    a_resp_ready[v.r] = 1'b1;
    @(negedge clk);
    a_resp_ready[v.r] = 1'b0;
    #1;
    check("done", 64'({a_resp_v, a_busy}), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   ng;
    int   cyc;
    int   last_c;
    int   inflight_err;
    int   period_err;
    int   stable_err;
    logic order[6];
    logic [1:0]  hold_v;
    logic [31:0] hold_d;
    vec_t v;

    vecs[0] = '{0, 1'b0, 14'h0010, 2'd2, 32'h0000_0000, 32'hDEADBEEF, 3};
    vecs[1] = '{1, 1'b1, 14'h0800, 2'd2, 32'h1234_5678, 32'h0000_0000, 2};
    vecs[2] = '{0, 1'b1, 14'h3FFF, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[3] = '{1, 1'b0, 14'h3FFF, 2'd1, 32'h5555_AAAA, 32'hA500_3FFF, 3};
    vecs[4] = '{1, 1'b0, 14'h0000, 2'd2, 32'h0000_0001, 32'hA500_0000, 3};

    rst_n = 1'b0;
    a_req_v = 2'b11; a_req_we = '0; a_req_addr = '0; a_req_size = '0; a_req_data = '0;
    a_resp_ready = '0;
    b_req_v = '0; b_req_we = '1; b_req_addr = '0; b_req_size = '0; b_req_data = '0;
    b_resp_ready = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          64'({a_req_ready, a_resp_v, a_resp_data, a_wen, a_ren, a_mmio_addr, a_mmio_size, a_busy}), 64'(0));
    a_req_v = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) txn(vecs[i]);

    // contention: both requesters always valid, writes back to back from reset
    do_reset();
    a_req_we = 2'b11;
    a_req_addr = {14'h0222, 14'h0111};
    a_req_data = {32'h2222_2222, 32'h1111_1111};
    a_resp_ready = 2'b11;
    a_req_v = 2'b11;
    ng = 0; cyc = 0; last_c = 0; inflight_err = 0; period_err = 0;
    while (ng < 6 && cyc < 60) begin
      #1;
      if (a_req_ready != 2'b00) begin
        if (a_busy || !(a_req_ready == 2'b01 || a_req_ready == 2'b10)) inflight_err++;
        order[ng] = (a_req_ready == 2'b10);
        if (ng > 0 && cyc - last_c != 3) period_err++;
        last_c = cyc;
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    a_req_v = 2'b00;
    check("cont_count", 64'(ng), 64'(6));
    for (int i = 0; i < 6; i++) check("cont_order", 64'(order[i]), 64'(i % 2));
    check("cont_inflight", 64'(inflight_err), 64'(0));
    check("cont_period", 64'(period_err), 64'(0));
    n = 0;
    while (a_busy && n < 20) begin @(negedge clk); n++; end
    check("cont_drain", 64'(a_busy), 64'(0));
    a_resp_ready = 2'b00;

    // response backpressure with a competing requester and a non-owner ready
    @(negedge clk);
    a_req_we = 2'b10;
    a_req_addr = {14'h0333, 14'h0020};
    a_req_v[0] = 1'b1;
    #1;
    check("bp_grant0", 64'(a_req_ready), 64'(2'b01));
    @(negedge clk);
    a_req_v = 2'b10;
    a_resp_ready = 2'b10;
    n = 0;
    #1;
    while (a_resp_v == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    check("bp_resp", 64'({a_resp_v, a_resp_data}), 64'({2'b01, 32'hA500_0020}));
    hold_v = a_resp_v; hold_d = a_resp_data; stable_err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (a_resp_v != hold_v || a_resp_data != hold_d || a_req_ready != 2'b00) stable_err++;
    end
    check("bp_stable", 64'(stable_err), 64'(0));
    a_resp_ready = 2'b01;
    @(negedge clk); #1;
    check("bp_next_grant", 64'({a_resp_v, a_req_ready}), 64'({2'b00, 2'b10}));
    a_resp_ready = 2'b11;
    @(negedge clk);
    a_req_v = 2'b00;
    n = 0;
    while (a_busy && n < 20) begin @(negedge clk); n++; end
    check("bp_drain", 64'(a_busy), 64'(0));
    a_resp_ready = 2'b00;

    // reset in the read-data cycle with the pointer sitting at 1
    v = '{0, 1'b1, 14'h0044, 2'd2, 32'hCAFE_0001, 32'h0, 2};
    txn(v);
    @(negedge clk);
    a_req_we[1] = 1'b0;
    a_req_addr[27:14] = 14'h0055;
    a_req_v[1] = 1'b1;
    #1;
    check("mid_grant1", 64'(a_req_ready), 64'(2'b10));
    @(negedge clk);
    a_req_v = 2'b00;
    @(negedge clk); #1;
    check("mid_in_rdata", 64'({a_busy, a_wen, a_ren, a_resp_v}), 64'({1'b1, 1'b0, 1'b0, 2'b00}));
    a_req_v = 2'b11;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          64'({a_req_ready, a_resp_v, a_resp_data, a_wen, a_ren, a_mmio_addr, a_mmio_size, a_busy}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_ptr_zero", 64'({a_req_ready, a_resp_v}), 64'({2'b01, 2'b00}));
    a_req_v = 2'b00;
    txn(vecs[0]);

    // four requesters: move pointer to 2, then 1 and 3 compete
    b_resp_ready = 4'hF;
    @(negedge clk);
    b_req_v = 4'b0010;
    #1;
    check("b_first", 64'(b_req_ready), 64'(4'b0010));
    @(negedge clk);
    b_req_v = 4'b0000;
    n = 0;
    while (b_busy && n < 20) begin @(negedge clk); n++; end
    b_req_v = 4'b1010;
    #1;
    check("b_grant3", 64'(b_req_ready), 64'(4'b1000));
    @(negedge clk);
    b_req_v = 4'b0010;
    n = 0;
    #1;
    while (b_req_ready == 4'b0000 && n < 20) begin @(negedge clk); #1; n++; end
    check("b_grant1", 64'(b_req_ready), 64'(4'b0010));
    @(negedge clk);
    b_req_v = 4'b0000;
    n = 0;
    while (b_busy && n < 20) begin @(negedge clk); n++; end
    check("b_drain", 64'(b_busy), 64'(0));

    check("en_exclusive", 64'(both_err), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
